fifo_read_ctrl: RTL and testbench

// Read-domain controller of the asynchronous FIFO: owns the read pointer, synchronises the write

---
 rtl/fifo_read_ctrl_if.sv | 27 ++
 rtl/fifo_read_ctrl.sv | 96 +++++++++
 tb/tb_fifo_read_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle of the async FIFO: consumer handshake, RAM read port and
// the Gray pointers exchanged with the write domain.
interface fifo_read_ctrl_if #(
    parameter int FIFO_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  r_en;
    logic [ADDR_WIDTH:0]   wptr_gray_async;
    logic [FIFO_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  empty;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   fill_level;

    modport master (
        output r_en, wptr_gray_async, mem_rdata,
        input  raddr, rptr_gray, data_out, rd_valid, empty, underflow, fill_level
    );

    modport slave (
        input  r_en, wptr_gray_async, mem_rdata,
        output raddr, rptr_gray, data_out, rd_valid, empty, underflow, fill_level
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, write-pointer
// synchroniser, empty/fill flags and registered read data.
module fifo_read_ctrl #(
    parameter int FIFO_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    fifo_read_ctrl_if.slave  bus
);
    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]         sync_r [SYNC_STAGES];
    logic [PW-1:0]         rbin_r;
    logic [PW-1:0]         rptr_gray_r;
    logic [FIFO_WIDTH-1:0] data_out_r;
    logic                  rd_valid_r;
    logic                  empty_r;
    logic                  underflow_r;
    logic [PW-1:0]         fill_level_r;

    logic [PW-1:0]         wgray_s;
    logic [PW-1:0]         wbin_s;
    logic                  accept_s;
    logic [PW-1:0]         rbin_next_s;
    logic [PW-1:0]         rgray_next_s;

    assign wgray_s = sync_r[SYNC_STAGES-1];

    // Post-accept pointer drives both the pointer update and the look-ahead flags.
    always_comb begin
        wbin_s   = gray2bin(wgray_s);
        accept_s = bus.r_en & ~empty_r;
        if (accept_s) begin
            rbin_next_s = rbin_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rbin_next_s = rbin_r;
        end
        rgray_next_s = bin2gray(rbin_next_s);
    end

    // Synchroniser, read pointer, flags and data register.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            rbin_r       <= '0;
            rptr_gray_r  <= '0;
            data_out_r   <= '0;
            rd_valid_r   <= 1'b0;
            empty_r      <= 1'b1;
            underflow_r  <= 1'b0;
            fill_level_r <= '0;
        end else begin
            sync_r[0] <= bus.wptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            rbin_r       <= rbin_next_s;
            rptr_gray_r  <= rgray_next_s;
            rd_valid_r   <= accept_s;
            underflow_r  <= bus.r_en & empty_r;
            // Comparing against the post-accept pointer lets empty rise on the edge that takes the last word.
            empty_r      <= (rgray_next_s == wgray_s);
            fill_level_r <= wbin_s - rbin_next_s;
            if (accept_s) begin
                data_out_r <= bus.mem_rdata;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign bus.raddr      = rbin_r[ADDR_WIDTH-1:0];
    assign bus.rptr_gray  = rptr_gray_r;
    assign bus.data_out   = data_out_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.empty      = empty_r;
    assign bus.underflow  = underflow_r;
    assign bus.fill_level = fill_level_r;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: reset, sync latency, underflow,
// wrap-around, full drain and reset mid-burst.
module tb_fifo_read_ctrl;
    localparam int FW = 32;
    localparam int AW = 4;

    logic rclk;
    logic rrst_n;
    int   n_total;
    int   n_bad;
    logic [FW-1:0] mem [16];

    fifo_read_ctrl_if #(.FIFO_WIDTH(FW), .ADDR_WIDTH(AW)) bus ();

    fifo_read_ctrl #(.FIFO_WIDTH(FW), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus.slave)
    );

    assign bus.mem_rdata = mem[bus.raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    function automatic logic [31:0] mem_exp(input int a);
        return (a == 0) ? 32'hDEADBEEF : (32'hC0DE0000 + a);
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < 16; i++) mem[i] = mem_exp(i);

        // 1: reset beats r_en
        rrst_n = 1'b0;
        bus.r_en = 1'b1;
        bus.wptr_gray_async = 5'b00011;
        tick();
        check_val("rst_empty", bus.empty, 32'd1);
        check_val("rst_data", bus.data_out, 32'd0);
        check_val("rst_rptr", bus.rptr_gray, 32'd0);
        check_val("rst_valid", bus.rd_valid, 32'd0);
        check_val("rst_uflow", bus.underflow, 32'd0);
        check_val("rst_fill", bus.fill_level, 32'd0);

        // 2: single write becomes visible after three edges, then one read
        rrst_n = 1'b1;
        bus.r_en = 1'b0;
        bus.wptr_gray_async = 5'b00000;
        tick();
        bus.wptr_gray_async = 5'b00001;
        tick();
        check_val("sync_e1", bus.empty, 32'd1);
        tick();
        check_val("sync_e2", bus.empty, 32'd1);
        tick();
        check_val("sync_e3", bus.empty, 32'd0);
        check_val("sync_fill", bus.fill_level, 32'd1);
        bus.r_en = 1'b1;
        tick();
        check_val("rd1_data", bus.data_out, 32'hDEADBEEF);
        check_val("rd1_valid", bus.rd_valid, 32'd1);
        check_val("rd1_rptr", bus.rptr_gray, 32'd1);
        check_val("rd1_empty", bus.empty, 32'd1);
        check_val("rd1_fill", bus.fill_level, 32'd0);

        // 3: two reads while empty are dropped
        tick();
        check_val("uf1_flag", bus.underflow, 32'd1);
        check_val("uf1_valid", bus.rd_valid, 32'd0);
        check_val("uf1_rptr", bus.rptr_gray, 32'd1);
        tick();
        check_val("uf2_flag", bus.underflow, 32'd1);
        check_val("uf2_data", bus.data_out, 32'hDEADBEEF);
        check_val("uf2_rptr", bus.rptr_gray, 32'd1);
        bus.r_en = 1'b0;
        tick();
        check_val("uf_clear", bus.underflow, 32'd0);

        // 4: advance to rbin=15, then read across the wrap
        bus.wptr_gray_async = 5'b01000;
        tick(); tick(); tick();
        check_val("w15_fill", bus.fill_level, 32'd14);
        bus.r_en = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        bus.r_en = 1'b0;
        check_val("r15_empty", bus.empty, 32'd1);
        check_val("r15_rptr", bus.rptr_gray, 32'b01000);
        bus.wptr_gray_async = 5'b11001;
        tick(); tick(); tick();
        check_val("w17_fill", bus.fill_level, 32'd2);
        check_val("w17_raddr", bus.raddr, 32'd15);
        bus.r_en = 1'b1;
        tick();
        check_val("wrap_data15", bus.data_out, mem_exp(15));
        check_val("wrap_rptr16", bus.rptr_gray, 32'b11000);
        check_val("wrap_raddr0", bus.raddr, 32'd0);
        tick();
        check_val("wrap_data0", bus.data_out, 32'hDEADBEEF);
        check_val("wrap_rptr17", bus.rptr_gray, 32'b11001);
        check_val("wrap_empty", bus.empty, 32'd1);
        bus.r_en = 1'b0;

        // 5: full FIFO drained back-to-back
        rrst_n = 1'b0;
        bus.wptr_gray_async = 5'b00000;
        tick();
        rrst_n = 1'b1;
        bus.wptr_gray_async = 5'b11000;
        tick(); tick(); tick();
        check_val("full_fill", bus.fill_level, 32'd16);
        check_val("full_empty", bus.empty, 32'd0);
        bus.r_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_val("drain_valid", bus.rd_valid, 32'd1);
            check_val("drain_data", bus.data_out, mem_exp(i));
            check_val("drain_fill", bus.fill_level, 32'(15 - i));
            check_val("drain_empty", bus.empty, (i == 15) ? 32'd1 : 32'd0);
            check_val("drain_uflow", bus.underflow, 32'd0);
        end
        bus.r_en = 1'b0;
        tick();

        // 6: reset in the middle of a burst
        bus.wptr_gray_async = 5'b10100;
        tick(); tick(); tick();
        check_val("mid_fill", bus.fill_level, 32'd8);
        bus.r_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_val("mid_raddr", bus.raddr, 32'd5);
        rrst_n = 1'b0;
        tick();
        check_val("mrst_rptr", bus.rptr_gray, 32'd0);
        check_val("mrst_raddr", bus.raddr, 32'd0);
        check_val("mrst_valid", bus.rd_valid, 32'd0);
        check_val("mrst_empty", bus.empty, 32'd1);
        check_val("mrst_data", bus.data_out, 32'd0);
        rrst_n = 1'b1;
        bus.r_en = 1'b0;
        tick(); tick(); tick();
        check_val("post_fill", bus.fill_level, 32'd24);
        check_val("post_empty", bus.empty, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
